// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first,
// optional parity, then 1 or 2 stop bits; all outputs registered.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_tx,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx
);

    // Despite its name, rst_n is asserted high.
    localparam int STOP_LEN = STOP_BITS * CLKS_PER_BIT;
    localparam int CW       = $clog2(STOP_LEN);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);
    localparam logic          PAR_EN    = (PARITY_EN != 0);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, bit-period counter, bit index and byte capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (start_tx) begin
                    data_d  = tx_data;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == STOP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs follow the state being entered, so tx moves on the same edge.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_STOP) && (state_d == S_IDLE);
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_d[bit_d];
            S_PARITY: tx_d = (^data_q) ^ PAR_ODD;
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: default framing on u0,
// parity with two stop bits on u1 (4 clocks per bit).
`timescale 1ns/1ps
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_tx, start1;
    logic [7:0] tx_data, data1;
    logic       tx0, busy0, done0;
    logic       tx1, busy1, done1;

    int n_cmp = 0;
    int n_err = 0;
    int mon_cnt = 0;

    logic txs [0:399];
    logic bs  [0:399];
    logic ds  [0:399];
    logic t1s [0:99];
    logic b1s [0:99];
    logic d1s [0:99];

    int bc, lc, dc, df, ov, rs, m0, s1, st1;

    always #5 clk = ~clk;

    uart_transmitter u0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_tx (start_tx),
        .tx_data  (tx_data),
        .tx_busy  (busy0),
        .tx_done  (done0),
        .tx       (tx0)
    );

    uart_transmitter #(
        .CLKS_PER_BIT (4),
        .PARITY_EN    (1),
        .PARITY_ODD   (0),
        .STOP_BITS    (2)
    ) u1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_tx (start1),
        .tx_data  (data1),
        .tx_busy  (busy1),
        .tx_done  (done1),
        .tx       (tx1)
    );

    always @(negedge clk) begin
        if (done0) begin
            mon_cnt++;
            $display("Transmission Complete");
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Record one sample per negedge; optional mid-frame data change and request release.
    task automatic cap(input int n, input int chg_at,
                       input logic [7:0] chg_val, input int rel_at);
        for (int i = 0; i < n; i++) begin
            txs[i] = tx0;
            bs[i]  = busy0;
            ds[i]  = done0;
            if (i < 100) begin
                t1s[i] = tx1;
                b1s[i] = busy1;
                d1s[i] = done1;
            end
            if (i == chg_at) tx_data = chg_val;
            if (i == rel_at) begin
                start_tx = 1'b0;
                start1   = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic stats(input int n, output int b, output int l,
                         output int d, output int f, output int o,
                         output int r);
        b = 0; l = 0; d = 0; f = -1; o = 0; r = 0;
        for (int i = 0; i < n; i++) begin
            if (bs[i]) b++;
            if (bs[i] && !txs[i]) l++;
            if (ds[i]) begin
                d++;
                if (f < 0) f = i;
            end
            if (bs[i] && ds[i]) o++;
            if (bs[i] && (i == 0 || !bs[i-1])) r++;
        end
    endtask

    logic [9:0] a5_exp  = 10'b1101001010;
    logic [9:0] p07_exp = 10'b1000001110;

    initial begin
        rst_n    = 1'b1;
        start_tx = 1'b0;
        start1   = 1'b0;
        tx_data  = 8'h00;
        data1    = 8'h00;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_idle", int'({tx0, busy0, done0, tx1, busy1, done1}), 'b100100);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_idle", int'({tx0, busy0, done0, tx1, busy1, done1}), 'b100100);
        end

        tx_data  = 8'h00;
        start_tx = 1'b1;
        @(negedge clk);
        m0 = mon_cnt;
        cap(200, -1, 8'h00, 0);
        stats(200, bc, lc, dc, df, ov, rs);
        chk("b00_busy_cycles", bc, 160);
        chk("b00_low_cycles", lc, 144);
        chk("b00_done_count", dc, 1);
        chk("b00_done_pos", df, 160);
        chk("b00_busy_done_overlap", ov, 0);
        chk("b00_monitor", mon_cnt - m0, 1);
        chk("b00_line_idle", int'(txs[199]), 1);

        tx_data  = 8'hA5;
        start_tx = 1'b1;
        @(negedge clk);
        cap(200, 20, 8'h3C, 0);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("a5_bit%0d", k), int'(txs[16*k+8]), int'(a5_exp[k]));
        end
        stats(200, bc, lc, dc, df, ov, rs);
        chk("a5_busy_cycles", bc, 160);

        tx_data  = 8'h55;
        start_tx = 1'b1;
        @(negedge clk);
        cap(200, -1, 8'h00, 9);
        stats(200, bc, lc, dc, df, ov, rs);
        chk("long_req_frames", rs, 1);
        chk("long_req_done", dc, 1);
        chk("long_req_busy", bc, 160);

        tx_data  = 8'h55;
        start_tx = 1'b1;
        @(negedge clk);
        cap(340, -1, 8'h00, 200);
        stats(340, bc, lc, dc, df, ov, rs);
        chk("b2b_frames", rs, 2);
        chk("b2b_done", dc, 2);
        chk("b2b_busy", bc, 320);
        chk("b2b_done1_pos", df, 160);
        chk("b2b_done2", int'(ds[321]), 1);
        chk("b2b_gap_busy", int'(bs[160]), 0);
        chk("b2b_gap_tx", int'(txs[160]), 1);
        chk("b2b_second_start", int'(txs[161]), 0);
        chk("b2b_overlap", ov, 0);

        data1  = 8'h07;
        start1 = 1'b1;
        @(negedge clk);
        cap(60, -1, 8'h00, 0);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("par_bit%0d", k), int'(t1s[4*k+2]), int'(p07_exp[k]));
        end
        s1 = 0;
        st1 = 0;
        for (int i = 0; i < 60; i++) begin
            if (b1s[i]) s1++;
            if (i >= 40 && i < 48 && t1s[i] && b1s[i]) st1++;
        end
        chk("par_busy_cycles", s1, 48);
        chk("par_stop_high", st1, 8);
        chk("par_done_pos", int'(d1s[48]), 1);
        chk("par_done_width", int'(d1s[49]), 0);

        tx_data  = 8'h00;
        start_tx = 1'b1;
        @(negedge clk);
        cap(70, -1, 8'h00, 0);
        chk("mid_pre_tx", int'(tx0), 0);
        chk("mid_pre_busy", int'(busy0), 1);
        m0 = mon_cnt;
        rst_n = 1'b1;
        #1;
        chk("mid_async_tx", int'(tx0), 1);
        chk("mid_async_busy", int'(busy0), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_no_done", mon_cnt - m0, 0);
        chk("mid_idle", int'({tx0, busy0, done0}), 'b100);

        tx_data  = 8'h00;
        start_tx = 1'b1;
        @(negedge clk);
        cap(200, -1, 8'h00, 0);
        stats(200, bc, lc, dc, df, ov, rs);
        chk("post_busy_cycles", bc, 160);
        chk("post_low_cycles", lc, 144);
        chk("post_done_pos", df, 160);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serial UART transmitter. It accepts one 8-bit byte per request and shifts it out on a single line as an asynchronous frame: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. It sits between a byte-wide producer (CPU or FIFO) and the board TX pin. The producer is told when the transmitter is busy and when a frame has completed.

Parameters:
CLKS_PER_BIT, 16, clock cycles per bit period; must be >= 2.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  reset; asynchronous, active-high (asserted when 1).
start_tx  input  1  transmit request, level-sampled while idle.
tx_data  input  8  byte to send; captured when the request is accepted.
tx_busy  output  1  high while a frame is in progress.
tx_done  output  1  one-cycle pulse at frame completion.
tx  output  1  serial line; idles high.

Behaviour:
- Reset (rst_n=1, asynchronous): tx=1, tx_busy=0, tx_done=0, state=IDLE, bit and cycle counters cleared. This applies at any time, including mid-frame; the partial frame is abandoned and the line returns high immediately.
- All outputs are registered; tx is glitch-free.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, tx_busy=0.
  - If start_tx=1 at a rising edge, then on that edge: latch tx_data into the shift register, set tx=0, set tx_busy=1, enter START.
- START: hold tx=0 for CLKS_PER_BIT cycles, then enter DATA with tx=data[0].
- DATA:
  - Each bit is held CLKS_PER_BIT cycles; bits are sent data[0]..data[7].
  - After bit 7, go to PARITY if PARITY_EN=1, otherwise STOP.
- PARITY: tx = XOR of the 8 latched bits, XORed with PARITY_ODD. Held CLKS_PER_BIT cycles, then STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the edge ending the last stop period: return to IDLE, tx_busy=0, tx_done=1 for exactly one cycle.
- Frame length: (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles. Latency from the accepting edge to the tx falling edge is 0 cycles; tx changes on the accepting edge itself.
- start_tx and tx_data are ignored while tx_busy=1. Changes to tx_data mid-frame do not affect the frame in flight.
- start_tx held high continuously: a new frame is accepted at the first IDLE edge. This is the edge on which tx_done is high, so back-to-back frames are separated by exactly one clock of idle-high line.
- tx_done and tx_busy are never high in the same cycle.
- start_tx asserted during reset has no effect. After reset releases, a still-high start_tx is accepted at the next edge.

Test Plan:
- Reset: assert rst_n=1 for 10 cycles with start_tx=0 -> tx=1, tx_busy=0, tx_done=0 throughout. Release; outputs stay unchanged with no request.
- Single byte 0x00, defaults: pulse start_tx for 1 cycle -> tx low for 9*16=144 cycles, then high for 16 cycles. tx_busy high for exactly 160 cycles. tx_done is a 1-cycle pulse as tx_busy falls. Monitor prints "Transmission Complete" once.
- Byte 0xA5, LSB first: sample tx mid-bit -> 0,1,0,1,0,0,1,0,1,1. Changing tx_data to 0x3C during the frame does not alter the bits.
- Long request: start_tx held high for 10 cycles with 0x55 -> exactly one frame is sent. Then hold start_tx high for two frames -> frames separated by a single idle-high cycle, and tx_done pulses twice.
- Parity: PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, byte 0x07 -> parity bit 1, then 2 stop periods. Total frame is 12*CLKS_PER_BIT cycles.
- Reset mid-frame: assert rst_n during data bit 3 -> tx=1 and tx_busy=0 immediately (asynchronous), no tx_done pulse. The next request transmits a clean, full frame.
